mmio_timer: RTL and testbench

//  Memory-mapped countdown timer: the responder behind the CPU store/load path at 0x7F00 (timer 0) / 0x7F10 (timer 1).

---
 rtl/mmio_timer_if.sv | 19 +
 rtl/mmio_timer.sv | 116 +++++++++++
 tb/tb_mmio_timer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_timer_if.sv
// mmio_timer_if: word-level register bus between the CPU bridge and the timer.
// master is the bridge side, slave is the timer side.
interface mmio_timer_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (
    output addr, we, wdata,
    input  rdata, irq
  );

  modport slave (
    input  addr, we, wdata,
    output rdata, irq
  );
endinterface

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped countdown timer with CTRL/PRESET/COUNT and irq.
// Optional prescaler enabled by defining TC_PRESCALE_EN.
module mmio_timer #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  mmio_timer_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT,
    S_INT
  } state_t;

  state_t      state;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        flag;
  logic        ctrl_wr;
  logic        en_eff;
  logic        tick;

  assign ctrl_wr = bus.we && (bus.addr == 2'd0);
  // A CTRL write landing this cycle overrides the stored EN for CNT.
  assign en_eff  = ctrl_wr ? bus.wdata[0] : ctrl[0];

`ifdef TC_PRESCALE_EN
  localparam logic [31:0] PRE_MAX = PRESCALE - 1;
  logic [31:0] pre_q;

  assign tick = (pre_q == PRE_MAX);

  // Prescaler runs only while counting; cleared on tick, LOAD and exit.
  always_ff @(posedge clk) begin
    if (!reset_n)
      pre_q <= '0;
    else if (state == S_CNT && en_eff && !tick)
      pre_q <= pre_q + 32'd1;
    else
      pre_q <= '0;
  end
`else
  logic unused_cfg;

  assign tick       = 1'b1;
  assign unused_cfg = ^PRESCALE;
`endif

  // Register file writes plus the countdown FSM; FSM updates override.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      ctrl   <= '0;
      preset <= '0;
      count  <= '0;
      flag   <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        ctrl <= bus.wdata[3:0];
        flag <= 1'b0;
      end
      if (bus.we && bus.addr == 2'd1)
        preset <= bus.wdata;

      unique case (state)
        S_IDLE: begin
          if (ctrl[0])
            state <= S_LOAD;
        end
        S_LOAD: begin
          count <= preset;
          state <= S_CNT;
        end
        S_CNT: begin
          if (!en_eff) begin
            state <= S_IDLE;
          end else if (tick) begin
            if (count > 32'd1) begin
              count <= count - 32'd1;
            end else begin
              count <= '0;
              flag  <= 1'b1;
              state <= S_INT;
            end
          end
        end
        S_INT: begin
          if (ctrl[2:1] == 2'd1) begin
            flag  <= 1'b0;
            state <= S_LOAD;
          end else begin
            if (!ctrl_wr)
              ctrl[0] <= 1'b0;
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Combinational read mux; reserved word reads zero.
  always_comb begin
    bus.rdata = '0;
    unique case (bus.addr)
      2'd0: bus.rdata = {28'b0, ctrl};
      2'd1: bus.rdata = preset;
      2'd2: bus.rdata = count;
      2'd3: bus.rdata = '0;
    endcase
  end

  assign bus.irq = flag & ctrl[3];
endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed stimulus with a queued scoreboard.
// A negedge monitor pops expected rdata/irq whenever a sample is posted.
module tb_mmio_timer;
  typedef struct {
    logic [95:0] name;
    logic [31:0] rdata;
    logic        irq;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic sample;
  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  mmio_timer_if bus();

  mmio_timer #(.PRESCALE(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sample) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard underflow: sample with empty queue");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_chk++;
        if (bus.rdata !== e.rdata) begin
          n_fail++;
          $display("FAIL %0s rdata got %h exp %h",
                   e.name, bus.rdata, e.rdata);
        end
        n_chk++;
        if (bus.irq !== e.irq) begin
          n_fail++;
          $display("FAIL %0s irq got %b exp %b",
                   e.name, bus.irq, e.irq);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ck(input logic [95:0] nm,
                    input logic [1:0]  a,
                    input logic [31:0] rd,
                    input logic        ir);
    exp_t e;
    bus.addr = a;
    e.name   = nm;
    e.rdata  = rd;
    e.irq    = ir;
    exp_q.push_back(e);
    sample = 1'b1;
    @(negedge clk);
    #1;
    sample = 1'b0;
    step();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.we    = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    step();
    bus.we    = 1'b0;
  endtask

  task automatic wck(input logic [1:0]  a,
                     input logic [31:0] d,
                     input logic [95:0] nm,
                     input logic [31:0] rd,
                     input logic        ir);
    bus.we    = 1'b1;
    bus.wdata = d;
    ck(nm, a, rd, ir);
    bus.we    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    sample    = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = 2'd0;
    bus.wdata = '0;
    step();
    step();
    ck("rst_ctrl", 0, 32'h0, 1'b0);
    ck("rst_pre", 1, 32'h0, 1'b0);
    ck("rst_cnt", 2, 32'h0, 1'b0);
    reset_n = 1'b1;

    ck("rsv_rd", 3, 32'h0, 1'b0);
    wr(3, 32'hFFFF_FFFF);
    wr(0, 32'hFFFF_FFF0);
    ck("ctrl_hi", 0, 32'h0, 1'b0);
    wr(1, 32'hA5A5_5A5A);
    ck("pre_rw", 1, 32'hA5A5_5A5A, 1'b0);
    ck("rsv_wr", 3, 32'h0, 1'b0);
    ck("cnt_idle", 2, 32'h0, 1'b0);

`ifdef TC_PRESCALE_EN
    wr(1, 32'd2);
    wr(0, 32'h9);
    for (int c = 0; c <= 10; c++)
      ck("t6_cnt", 2,
         (c < 2) ? 32'd0 : (c < 6) ? 32'd2 : (c < 10) ? 32'd1 : 32'd0,
         c == 10);
    wr(0, 32'h0);
    ck("t6_clr", 0, 32'h0, 1'b0);
`else
    // One-shot, PRESET=3
    wr(1, 32'd3);
    wr(0, 32'h9);
    ck("t2_c0", 2, 32'd0, 1'b0);
    ck("t2_c1", 2, 32'd0, 1'b0);
    ck("t2_c2", 2, 32'd3, 1'b0);
    ck("t2_c3", 2, 32'd2, 1'b0);
    ck("t2_c4", 2, 32'd1, 1'b0);
    ck("t2_c5", 2, 32'd0, 1'b1);
    ck("t2_en0", 0, 32'h8, 1'b1);
    ck("t2_hold", 2, 32'd0, 1'b1);
    wr(0, 32'h0);
    ck("t2_clr", 0, 32'h0, 1'b0);

    // Auto-reload, PRESET=2: period 4
    wr(1, 32'd2);
    wr(0, 32'hB);
    for (int c = 0; c <= 12; c++)
      ck("t3_pulse", 0, 32'hB, (c == 4) || (c == 8) || (c == 12));
    wr(0, 32'h0);
    ck("t3_ld", 2, 32'd2, 1'b0);
    ck("t3_stop", 2, 32'd2, 1'b0);

    // IM=0: flag set silently, cleared by next CTRL write
    wr(1, 32'd1);
    wr(0, 32'h1);
    ck("t4_c0", 0, 32'h1, 1'b0);
    ck("t4_c1", 0, 32'h1, 1'b0);
    ck("t4_c2", 0, 32'h1, 1'b0);
    ck("t4_c3", 0, 32'h1, 1'b0);
    ck("t4_en0", 0, 32'h0, 1'b0);
    ck("t4_c5", 0, 32'h0, 1'b0);
    wr(0, 32'h9);
    ck("t4_r0", 2, 32'd0, 1'b0);
    ck("t4_r1", 2, 32'd0, 1'b0);
    ck("t4_r2", 2, 32'd1, 1'b0);
    ck("t4_r3", 2, 32'd0, 1'b1);
    wr(0, 32'h0);
    ck("t4_clr", 0, 32'h0, 1'b0);

    // COUNT write ignored, PRESET change deferred
    wr(1, 32'd4);
    wr(0, 32'h1);
    ck("t5_c0", 2, 32'd0, 1'b0);
    ck("t5_c1", 2, 32'd0, 1'b0);
    wck(2, 32'hFFFF, "t5_cwr", 32'd4, 1'b0);
    wck(1, 32'd7, "t5_pwr", 32'd4, 1'b0);
    ck("t5_c4", 2, 32'd2, 1'b0);
    ck("t5_pnew", 1, 32'd7, 1'b0);
    ck("t5_c6", 2, 32'd0, 1'b0);
    ck("t5_c7", 0, 32'h0, 1'b0);
    wr(0, 32'h1);
    ck("t5_r0", 2, 32'd0, 1'b0);
    ck("t5_r1", 2, 32'd0, 1'b0);
    ck("t5_r2", 2, 32'd7, 1'b0);
    ck("t5_r3", 2, 32'd6, 1'b0);
    wck(0, 32'h0, "t5_stop", 32'h1, 1'b0);
    ck("t5_frz", 2, 32'd5, 1'b0);
    ck("t5_frz2", 2, 32'd5, 1'b0);

    // EN=0 written while COUNT==1: no flag
    wr(1, 32'd1);
    wr(0, 32'h9);
    ck("t5b_c0", 2, 32'd5, 1'b0);
    ck("t5b_c1", 2, 32'd5, 1'b0);
    wck(0, 32'h8, "t5b_wr", 32'h9, 1'b0);
    ck("t5b_c3", 2, 32'd1, 1'b0);
    ck("t5b_c4", 0, 32'h8, 1'b0);
    wr(0, 32'h0);

    // Reset mid-count
    wr(1, 32'd9);
    wr(0, 32'h9);
    ck("t1_c0", 2, 32'd1, 1'b0);
    ck("t1_c1", 2, 32'd1, 1'b0);
    ck("t1_c2", 2, 32'd9, 1'b0);
    ck("t1_c3", 2, 32'd8, 1'b0);
    ck("t1_c4", 2, 32'd7, 1'b0);
    ck("t1_c5", 2, 32'd6, 1'b0);
    reset_n = 1'b0;
    ck("t1_c6", 2, 32'd5, 1'b0);
    reset_n = 1'b1;
    ck("t1_cnt", 2, 32'd0, 1'b0);
    ck("t1_ctrl", 0, 32'h0, 1'b0);
    ck("t1_pre", 1, 32'd0, 1'b0);
    ck("t1_idle", 2, 32'd0, 1'b0);
`endif

    step();
    step();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, exp 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
